// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment scan driver.
// Double-buffered display contents commit only at frame wrap, so a frame never tears.
module seg7_scan_driver #(
   parameter int unsigned NUM_DIGITS  = 4,
   parameter int unsigned REFRESH_DIV = 50000,
   parameter int unsigned GUARD       = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4*NUM_DIGITS-1:0] data_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   blank_in,
   input  logic                    load,
   input  logic                    lz_suppress,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    frame_done
);

   localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int unsigned DW    = 4 * NUM_DIGITS;

   logic [CNT_W-1:0]      div_cnt;
   logic [IDX_W-1:0]      idx;
   logic [DW-1:0]         data_act, data_sh;
   logic [NUM_DIGITS-1:0] dp_act, dp_sh;
   logic [NUM_DIGITS-1:0] blank_act, blank_sh;
   logic                  pending;
   logic                  wrap_q;

   logic                  slot_end;
   logic                  frame_wrap;
   logic                  in_guard;
   logic [3:0]            cur_nib;
   logic                  cur_dp;
   logic                  cur_blank;
   logic                  upper_zero;
   logic                  zero_run;
   logic                  dark;
   logic [NUM_DIGITS-1:0] an_sel;

   // Active-high abcdefg glyph for one hex nibble
   function automatic logic [6:0] glyph(input logic [3:0] n);
      case (n)
         4'h0: glyph = 7'h7E;
         4'h1: glyph = 7'h30;
         4'h2: glyph = 7'h6D;
         4'h3: glyph = 7'h79;
         4'h4: glyph = 7'h33;
         4'h5: glyph = 7'h5B;
         4'h6: glyph = 7'h5F;
         4'h7: glyph = 7'h70;
         4'h8: glyph = 7'h7F;
         4'h9: glyph = 7'h7B;
         4'hA: glyph = 7'h7D;
         4'hB: glyph = 7'h1F;
         4'hC: glyph = 7'h4E;
         4'hD: glyph = 7'h3D;
         4'hE: glyph = 7'h6F;
         default: glyph = 7'h47;
      endcase
   endfunction

   assign slot_end   = (div_cnt == CNT_W'(REFRESH_DIV - 1));
   assign frame_wrap = slot_end && (idx == IDX_W'(NUM_DIGITS - 1));
   assign in_guard   = (32'(div_cnt) < GUARD);

   // Slot divider and digit index; index wraps together with the last slot
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
         idx     <= '0;
      end else if (slot_end) begin
         div_cnt <= '0;
         idx     <= frame_wrap ? '0 : idx + 1'b1;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   // Shadow capture and frame-boundary commit; a load on the wrap cycle bypasses the shadow
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_act  <= '0;
         dp_act    <= '0;
         blank_act <= '0;
         data_sh   <= '0;
         dp_sh     <= '0;
         blank_sh  <= '0;
         pending   <= 1'b0;
      end else if (frame_wrap) begin
         if (load) begin
            data_act  <= data_in;
            dp_act    <= dp_in;
            blank_act <= blank_in;
         end else if (pending) begin
            data_act  <= data_sh;
            dp_act    <= dp_sh;
            blank_act <= blank_sh;
         end
         pending <= 1'b0;
      end else if (load) begin
         data_sh  <= data_in;
         dp_sh    <= dp_in;
         blank_sh <= blank_in;
         pending  <= 1'b1;
      end
   end

   // Select the scanned digit and track whether it and every digit above it is zero
   always_comb begin
      cur_nib    = 4'h0;
      cur_dp     = 1'b0;
      cur_blank  = 1'b0;
      upper_zero = 1'b0;
      zero_run   = 1'b1;
      an_sel     = '1;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         zero_run = zero_run & (data_act[4*k +: 4] == 4'h0);
         if (idx == IDX_W'(k)) begin
            cur_nib    = data_act[4*k +: 4];
            cur_dp     = dp_act[k];
            cur_blank  = blank_act[k];
            upper_zero = zero_run;
            an_sel[k]  = 1'b0;
         end
      end
   end

   // Digit 0 is never suppressed so a zero value still shows "0"
   assign dark = cur_blank | (lz_suppress & (idx != '0) & upper_zero);

   // Registered pin drive; guard cycles keep every anode off to avoid ghosting
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg        <= 7'h7F;
         dp         <= 1'b1;
         an         <= '1;
         wrap_q     <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         wrap_q     <= frame_wrap;
         frame_done <= wrap_q;
         if (in_guard) begin
            seg <= 7'h7F;
            dp  <= 1'b1;
            an  <= '1;
         end else begin
            an  <= an_sel;
            seg <= dark ? 7'h7F : ~glyph(cur_nib);
            dp  <= dark | ~cur_dp;
         end
      end
   end

endmodule
